// File: rtl/logic_arbiter.sv
// Two-requester arbiter in front of one shared bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR).
// Define LOGIC_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (requester 0 wins).
module logic_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] result;
  logic             illegal;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On contention the requester not served last wins; reset value 1 hands the first tie to requester 0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= req1_ready;
    end
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Readies are only ever offered from IDLE and never while reset is asserted.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = grant0;
          req1_ready = grant1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = req0_ready | req1_ready;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op_q)
      3'd0:    result = a_q & b_q;
      3'd1:    result = a_q | b_q;
      3'd2:    result = ~(a_q & b_q);
      3'd3:    result = ~(a_q | b_q);
      3'd4:    result = a_q ^ b_q;
      3'd5:    result = ~(a_q ^ b_q);
      default: illegal = 1'b1;
    endcase
  end

  // Operands are sampled only on the accept edge, so later requester activity cannot disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        id_q <= req1_ready;
        if (req1_ready) begin
          op_q <= req1_op;
          a_q  <= req1_a;
          b_q  <= req1_b;
        end else begin
          op_q <= req0_op;
          a_q  <= req0_a;
          b_q  <= req0_b;
        end
      end
      if (state == EXEC) begin
        rsp_data <= result;
        rsp_err  <= illegal;
        rsp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_logic_arbiter.sv
// Randomized, self-checking bench for logic_arbiter against a truth-table reference model.
module tb_logic_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int m_last = 1;

  logic [15:0] exp_all_ops [6] = '{16'h000F, 16'h0FFF, 16'hFFF0, 16'hF000, 16'h0FF0, 16'hF00F};

  logic_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: each opcode is a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [15:0] model_data(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [3:0]  tt;
    logic [15:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0111;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0110;
      3'd5:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < 16; i++) begin
      r[i] = tt[{a[i], b[i]}];
    end
    return r;
  endfunction

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    return (m_last == 1) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic scramble();
    req0_op = 3'($urandom);
    req0_a  = 16'($urandom);
    req0_b  = 16'($urandom);
    req1_op = 3'($urandom);
    req1_a  = 16'($urandom);
    req1_b  = 16'($urandom);
  endtask

  // Entered shortly after a rising edge with the DUT in IDLE; returns shortly after the handshake edge.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1,
                        input int stall, output logic [15:0] got_data, output logic got_id);
    int          w;
    logic [15:0] ed;
    logic        ee;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'b0;
    w  = pick(v0, v1);
    ed = (w == 1) ? model_data(o1, a1, b1) : model_data(o0, a0, b0);
    ee = ((w == 1) ? o1 : o0) > 3'd5;
    @(negedge clk);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("grant_req0", 32'(req0_ready), 32'(w == 0));
    check("grant_req1", 32'(req1_ready), 32'(w == 1));
    m_last = w;
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", 32'(rsp_data), 32'(ed));
      check("stall_rsp_id", 32'(rsp_id), 32'(w));
      check("stall_rsp_err", 32'(rsp_err), 32'(ee));
      check("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk); #1;
      scramble();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(ed));
    check("rsp_id", 32'(rsp_id), 32'(w));
    check("rsp_err", 32'(rsp_err), 32'(ee));
    got_data = rsp_data;
    got_id   = rsp_id;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic        id;
    int          exp_seq [4];
    bit          v0;
    bit          v1;

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = '0; req1_b = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; m_last = 1;
    repeat (2) begin
      @(negedge clk);
      check("idle_none_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("idle_none_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end

    // First contention after reset goes to requester 0 in either arbitration mode.
    run_op(1, 1, 3'd4, 16'h1234, 16'h00FF, 3'd1, 16'h0F00, 16'h00F0, 0, d, id);
    check("first_tie_id", 32'(id), 32'd0);

    run_op(1, 0, 3'd0, 16'hF0F0, 16'hFF00, 3'd0, 16'h0, 16'h0, 0, d, id);
    check("single_op_data", 32'(d), 32'h0000F000);

    for (int i = 0; i < 6; i++) begin
      run_op(1, 0, 3'(i), 16'h00FF, 16'h0F0F, 3'd0, 16'h0, 16'h0, 0, d, id);
      check("all_ops_data", 32'(d), 32'(exp_all_ops[i]));
    end

    run_op(0, 1, 3'd0, 16'h0, 16'h0, 3'd7, 16'hFFFF, 16'hAAAA, 0, d, id);
    check("illegal_data", 32'(d), 32'd0);
    check("illegal_id", 32'(id), 32'd1);

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1, 3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom),
             3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 0, d, id);
      check("contention_id", 32'(id), 32'(exp_seq[i]));
    end

    run_op(1, 1, 3'd2, 16'hA5A5, 16'h0FF0, 3'd3, 16'h1111, 16'h2222, 5, d, id);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("bp_back_idle", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset while the operation is in EXEC: it must vanish without a response.
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 16'hFFFF; req0_b = 16'h1234;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; m_last = 1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_op(0, 1, 3'd0, 16'h0, 16'h0, 3'd5, 16'h3C3C, 16'h0FF0, 1, d, id);
    check("after_rst_id", 32'(id), 32'd1);

    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v1 = 1'b1;
      run_op(v0, v1, 3'($urandom), 16'($urandom), 16'($urandom),
             3'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3), d, id);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
